// File: rtl/deser_pkg.sv
// Shared definitions for the serial word collector.
//   state_e : collector FSM encoding (IDLE = no word in progress, COLLECT = partial word held)
//   cnt_w() : bit-count register width for a given word width
package deser_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  // cnt only has to reach WIDTH-1, so clog2(WIDTH) bits are enough; keep at least 1.
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/deser_shreg.sv
// WIDTH-bit right-shifting register; new bits enter at the MSB so that after
// WIDTH shifts the first bit received sits in bit 0.
// Ports:
//   i_clk     : clock, rising edge
//   i_clr     : synchronous clear (has priority over shift)
//   i_shift   : shift enable
//   i_bit     : bit shifted in at the MSB
//   o_shifted : register contents as they will be after a shift of i_bit
//               (lets the owner capture a completed word on the same edge)
module deser_shreg #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_shift,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_shifted
);

  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_shifted;

  assign w_shifted = {i_bit, r_sr[WIDTH-1:1]};
  assign o_shifted = w_shifted;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_sr <= '0;
    end else if (i_shift) begin
      r_sr <= w_shifted;
    end
  end

endmodule

// File: rtl/serial_word_collector.sv
// Collects the LSB-first bit stream of the bit-serial inverter into WIDTH-bit
// words and offers them on a valid/ready port with a one-entry output buffer.
// Ports:
//   t_clk    : clock, rising edge
//   r        : synchronous active-high reset
//   s_bit    : serial data bit, LSB first
//   s_valid  : s_bit valid this cycle
//   s_first  : s_bit is bit 0 of a new word (qualified by s_valid)
//   m_data   : assembled word, stable while m_valid=1
//   m_valid  : m_data holds an unconsumed word
//   m_ready  : consumer accepts m_data when m_valid && m_ready
//   busy     : a word is partially collected
//   frm_err  : 1-cycle pulse, framing error (restart mid-word or stray bit in IDLE)
//   ovf      : 1-cycle pulse, completed word dropped because the buffer was full
//   drop_cnt : (only with DESER_DROP_CNT_EN) saturating count of ovf pulses
// Build option: define DESER_DROP_CNT_EN to add the drop_cnt port and counter.
module serial_word_collector
  import deser_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             t_clk,
  input  logic             r,
  input  logic             s_bit,
  input  logic             s_valid,
  input  logic             s_first,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             frm_err,
  output logic             ovf
`ifdef DESER_DROP_CNT_EN
  ,output logic [7:0]      drop_cnt
`endif
);

  localparam int CNT_W = cnt_w(WIDTH);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("serial_word_collector: WIDTH must be in 2..32");
  end

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_shift;
  logic             w_done;
  logic             w_frm_err;
  logic             w_load;
  logic             w_drop;
  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] r_m_data;
  logic             r_m_valid;
  logic             r_frm_err;
  logic             r_ovf;

  deser_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .i_clk    (t_clk),
    .i_clr    (r),
    .i_shift  (w_shift),
    .i_bit    (s_bit),
    .o_shifted(w_word)
  );

  always_ff @(posedge t_clk) begin
    if (r) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift     = 1'b0;
    w_done      = 1'b0;
    w_frm_err   = 1'b0;
    if (s_valid) begin
      if (s_first) begin
        // A restart mid-word drops the partial word; the stale shift-register
        // bits are pushed out by the WIDTH shifts of the new word.
        w_shift     = 1'b1;
        w_cnt_nxt   = CNT_W'(1);
        w_state_nxt = COLLECT;
        w_frm_err   = (r_state == COLLECT);
      end else if (r_state == IDLE) begin
        w_frm_err = 1'b1;
      end else begin
        w_shift = 1'b1;
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_done      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
    end
  end

  // The buffer accepts a completed word when empty or being drained this cycle.
  assign w_load = w_done && (!r_m_valid || m_ready);
  assign w_drop = w_done && r_m_valid && !m_ready;

  always_ff @(posedge t_clk) begin
    if (r) begin
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_frm_err <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_frm_err <= w_frm_err;
      r_ovf     <= w_drop;
      if (w_load) begin
        r_m_data  <= w_word;
        r_m_valid <= 1'b1;
      end else if (r_m_valid && m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

`ifdef DESER_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge t_clk) begin
    if (r) begin
      r_drop_cnt <= '0;
    end else if (r_ovf && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

  assign m_data  = r_m_data;
  assign m_valid = r_m_valid;
  assign busy    = (r_state == COLLECT);
  assign frm_err = r_frm_err;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_serial_word_collector.sv
// Directed bench for serial_word_collector at WIDTH=4.
module tb_serial_word_collector;

  localparam int WIDTH = 4;

  logic             t_clk   = 1'b0;
  logic             r       = 1'b1;
  logic             s_bit   = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_first = 1'b0;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             busy;
  logic             frm_err;
  logic             ovf;
`ifdef DESER_DROP_CNT_EN
  logic [7:0]       drop_cnt;
`endif

  int   n_total  = 0;
  int   n_pass   = 0;
  logic seen_err = 1'b0;

  always #5 t_clk = ~t_clk;

  serial_word_collector #(
    .WIDTH(WIDTH)
  ) dut (
    .t_clk   (t_clk),
    .r       (r),
    .s_bit   (s_bit),
    .s_valid (s_valid),
    .s_first (s_first),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .busy    (busy),
    .frm_err (frm_err),
    .ovf     (ovf)
`ifdef DESER_DROP_CNT_EN
    ,.drop_cnt(drop_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, act, exp);
  endtask

  // One input cycle: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic cyc(input logic v, input logic b, input logic f);
    @(negedge t_clk);
    s_valid = v;
    s_bit   = b;
    s_first = f;
    @(posedge t_clk);
    #1;
    seen_err = seen_err | frm_err | ovf;
  endtask

  // Sends a word LSB first with `gap` idle cycles between consecutive bits.
  task automatic send_word(input logic [3:0] w, input int gap);
    for (int k = 0; k < WIDTH; k++) begin
      if (k > 0) for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, w[k], (k == 0));
    end
  endtask

  logic [3:0] words [6] = '{4'h5, 4'hC, 4'h9, 4'h7, 4'h2, 4'hE};

  initial begin
    // Reset
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frm_err", frm_err, 0);
    check("rst_ovf", ovf, 0);
    r = 1'b0;

    // 1: stream 0,1,0,1 -> 1010
    m_ready = 1'b1;
    cyc(1'b1, 1'b0, 1'b1);
    check("t1_busy_b0", busy, 1);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check("t1_valid_b2", m_valid, 0);
    cyc(1'b1, 1'b1, 1'b0);
    check("t1_valid", m_valid, 1);
    check("t1_data", m_data, 4'b1010);
    check("t1_busy_done", busy, 0);
    cyc(1'b0, 1'b0, 1'b0);
    check("t1_consumed", m_valid, 0);

    // 2: held word A, word B dropped
    m_ready = 1'b0;
    send_word(4'b1010, 0);
    check("t2_a_valid", m_valid, 1);
    check("t2_a_data", m_data, 4'b1010);
    check("t2_a_ovf", ovf, 0);
    send_word(4'b0001, 0);
    check("t2_ovf", ovf, 1);
    check("t2_hold_data", m_data, 4'b1010);
    check("t2_hold_valid", m_valid, 1);
    cyc(1'b0, 1'b0, 1'b0);
    check("t2_ovf_pulse", ovf, 0);
    check("t2_data_after", m_data, 4'b1010);
`ifdef DESER_DROP_CNT_EN
    check("t2_drop_cnt", drop_cnt, 1);
`endif
    m_ready = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    check("t2_drained", m_valid, 0);

    // 3: restart after 2 bits, then 1,1,0,0 -> 0011
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    check("t3_no_err", frm_err, 0);
    cyc(1'b1, 1'b1, 1'b1);
    check("t3_frm_err", frm_err, 1);
    check("t3_busy", busy, 1);
    cyc(1'b1, 1'b1, 1'b0);
    check("t3_frm_pulse", frm_err, 0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check("t3_valid", m_valid, 1);
    check("t3_data", m_data, 4'b0011);

    // 4: stray bit while IDLE, buffer full
    m_ready = 1'b0;
    cyc(1'b1, 1'b1, 1'b0);
    check("t4_frm_err", frm_err, 1);
    check("t4_busy", busy, 0);
    check("t4_valid", m_valid, 1);
    check("t4_data", m_data, 4'b0011);
    cyc(1'b0, 1'b0, 1'b0);
    check("t4_frm_pulse", frm_err, 0);

    // 5: reset mid-word with a full buffer, then fresh word 1,0,0,0
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    check("t5_busy_pre", busy, 1);
    @(negedge t_clk);
    r = 1'b1;
    s_valid = 1'b0;
    s_first = 1'b0;
    @(posedge t_clk);
    #1;
    check("t5_rst_valid", m_valid, 0);
    check("t5_rst_data", m_data, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_flags", {frm_err, ovf}, 0);
`ifdef DESER_DROP_CNT_EN
    check("t5_rst_drop_cnt", drop_cnt, 0);
`endif
    r = 1'b0;
    send_word(4'b0001, 0);
    check("t5_valid", m_valid, 1);
    check("t5_data", m_data, 4'b0001);

    // 6: back-to-back words, in-word gaps 0..3, consumer always ready
    m_ready = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    seen_err = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send_word(words[i], i % 4);
      check($sformatf("t6_valid_%0d", i), m_valid, 1);
      check($sformatf("t6_data_%0d", i), m_data, words[i]);
    end
    cyc(1'b0, 1'b0, 1'b0);
    check("t6_drained", m_valid, 0);
    check("t6_no_err", seen_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
